// File: rtl/alarm_beeper_if.sv
// +----------------------------------------------------------------------+
// | alarm_beeper_if                                                      |
// | Alarm level / snooze key in, buzzer and status flags out.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface alarm_beeper_if;
    logic alarm_in;
    logic snooze;
    logic buzzer;
    logic ringing;
    logic snoozing;

    modport master (
        output alarm_in,
        output snooze,
        input  buzzer,
        input  ringing,
        input  snoozing
    );

    modport slave (
        input  alarm_in,
        input  snooze,
        output buzzer,
        output ringing,
        output snoozing
    );
endinterface

`default_nettype wire

// File: rtl/alarm_beeper.sv
// +----------------------------------------------------------------------+
// | alarm_beeper                                                         |
// | Double-beep square-wave tone generator with optional snooze timer.   |
// | Optional feature macro: SNOOZE_EN (snooze state and frame counter).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alarm_beeper #(
    parameter int SLOT_CNT    = 6553600,
    parameter int TONE_HALF   = 12800,
    parameter int SNOOZE_TIME = 5,
    parameter int CNT_W       = 26
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    alarm_beeper_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_SLOT_LAST = CNT_W'(SLOT_CNT - 1);
    localparam logic [CNT_W-1:0] c_TONE_LAST = CNT_W'(TONE_HALF - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [2:0]       slot_idx_q, slot_idx_d;
    logic             buzzer_q, buzzer_d;
    logic             ringing_q, ringing_d;
    logic             snoozing_q, snoozing_d;

    logic w_slot_wrap;
    logic w_tone_wrap;
    logic w_gate;
    logic w_restart;

    assign w_slot_wrap = (slot_cnt_q == c_SLOT_LAST);
    assign w_tone_wrap = (tone_cnt_q == c_TONE_LAST);
    assign w_gate      = (state_q == ST_RING) &&
                         ((slot_idx_q == 3'd0) || (slot_idx_q == 3'd2));

`ifdef SNOOZE_EN
    localparam logic [7:0] c_SNOOZE_T = 8'(SNOOZE_TIME);

    logic [7:0] frame_q, frame_d;
    logic       w_frame_wrap;
    logic       w_snooze_done;

    assign w_frame_wrap  = w_slot_wrap && (slot_idx_q == 3'd7);
    assign w_snooze_done = w_frame_wrap && ((frame_q + 8'd1) == c_SNOOZE_T);
`else
    logic unused_snooze;
    assign unused_snooze = bus.snooze;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.alarm_in) state_d = ST_RING;
            end
            ST_RING: begin
                if (!bus.alarm_in) state_d = ST_IDLE;
`ifdef SNOOZE_EN
                else if (bus.snooze) state_d = ST_SNOOZE;
`endif
            end
`ifdef SNOOZE_EN
            ST_SNOOZE: begin
                if (!bus.alarm_in)      state_d = ST_IDLE;
                else if (w_snooze_done) state_d = ST_RING;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Any state change (or idling) restarts the beep pattern at slot 0.
    always_comb begin
        w_restart  = (state_d != state_q) || (state_d == ST_IDLE);
        slot_cnt_d = slot_cnt_q;
        slot_idx_d = slot_idx_q;
        if (w_restart) begin
            slot_cnt_d = '0;
            slot_idx_d = 3'd0;
        end else if (w_slot_wrap) begin
            slot_cnt_d = '0;
            slot_idx_d = slot_idx_q + 3'd1;
        end else begin
            slot_cnt_d = slot_cnt_q + c_ONE;
        end
    end

`ifdef SNOOZE_EN
    always_comb begin
        frame_d = 8'd0;
        if ((state_q == ST_SNOOZE) && (state_d == ST_SNOOZE))
            frame_d = frame_q + {7'd0, w_frame_wrap};
    end
`endif

    // Tone runs only while gated; leaving the gate parks both at 0 so each beep starts low.
    always_comb begin
        tone_cnt_d = '0;
        buzzer_d   = 1'b0;
        if (w_gate && (state_d == ST_RING)) begin
            tone_cnt_d = w_tone_wrap ? '0 : (tone_cnt_q + c_ONE);
            buzzer_d   = buzzer_q ^ w_tone_wrap;
        end
        ringing_d  = (state_d != ST_IDLE);
`ifdef SNOOZE_EN
        snoozing_d = (state_d == ST_SNOOZE);
`else
        snoozing_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            slot_idx_q <= 3'd0;
            tone_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            slot_idx_q <= slot_idx_d;
            tone_cnt_q <= tone_cnt_d;
            buzzer_q   <= buzzer_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
        end
    end

`ifdef SNOOZE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) frame_q <= 8'd0;
        else       frame_q <= frame_d;
    end
`endif

    assign bus.buzzer   = buzzer_q;
    assign bus.ringing  = ringing_q;
    assign bus.snoozing = snoozing_q;

endmodule

`default_nettype wire
